// File: rtl/perf_section_marker.sv
// perf_section_marker: turns per-section begin/end pulses and a clear pulse
// into go/stop/reset writes on an Avalon-MM master port that drives the
// 4-section performance counter slave. Events wait in one pending flag each
// and are issued one write at a time. A pulse that finds its own flag already
// pending is counted in a saturating drop counter.
module perf_section_marker #(
    parameter int unsigned NUM_SECTIONS = 4,
    parameter int unsigned DROP_CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_SECTIONS-1:0] sec_begin,
    input  logic [NUM_SECTIONS-1:0] sec_end,
    input  logic                    clear_req,
    input  logic                    enable,
    output logic [3:0]              avm_address,
    output logic                    avm_write,
    output logic                    avm_begintransfer,
    output logic [31:0]             avm_writedata,
    input  logic                    avm_waitrequest,
    output logic                    busy,
    output logic [DROP_CNT_W-1:0]   drop_count
);

    // Flag vector layout: bit 0 = clear, bits 1..N = begin[i], bits N+1..2N = end[i].
    // Ascending bit order is also the arbitration priority order.
    localparam int unsigned NF = 2 * NUM_SECTIONS + 1;

    typedef enum logic {
        S_IDLE,
        S_ISSUE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [NF-1:0]           r_pend;
    logic [NF-1:0]           w_pend_nxt;
    logic [NF-1:0]           w_pulse;
    logic [NF-1:0]           w_clr;
    logic [NF-1:0]           w_drop;
    logic [3:0]              w_drop_num;
    logic [DROP_CNT_W+3:0]   w_drop_sum;
    logic [DROP_CNT_W-1:0]   r_drop_count;
    logic [DROP_CNT_W-1:0]   w_drop_nxt;

    logic [NF-1:0]           r_grant;
    logic [NF-1:0]           w_grant_nxt;
    logic [NF-1:0]           w_win_grant;
    logic [3:0]              w_win_addr;
    logic                    w_win_data;
    logic                    w_found;

    logic                    r_write;
    logic                    w_write_nxt;
    logic                    r_bt;
    logic                    w_bt_nxt;
    logic [3:0]              r_addr;
    logic [3:0]              w_addr_nxt;
    logic                    r_data0;
    logic                    w_data0_nxt;
    logic                    w_done;

    assign w_pulse = {sec_end, sec_begin, clear_req} & {NF{enable}};

    // Fixed-priority pick of the next pending event and its write encoding.
    always_comb begin
        w_win_grant = '0;
        w_win_addr  = '0;
        w_win_data  = 1'b0;
        w_found     = 1'b0;
        if (r_pend[0]) begin
            w_win_grant[0] = 1'b1;
            w_win_data     = 1'b1;
            w_found        = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_SECTIONS; i++) begin
            if (!w_found && r_pend[1+i]) begin
                w_win_grant[1+i] = 1'b1;
                w_win_addr       = 4'(4 * i + 1);
                w_found          = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_SECTIONS; i++) begin
            if (!w_found && r_pend[1+NUM_SECTIONS+i]) begin
                w_win_grant[1+NUM_SECTIONS+i] = 1'b1;
                w_win_addr                    = 4'(4 * i);
                w_found                       = 1'b1;
            end
        end
    end

    // FSM next state and next values of the registered master outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_write_nxt = r_write;
        w_bt_nxt    = r_bt;
        w_addr_nxt  = r_addr;
        w_data0_nxt = r_data0;
        w_grant_nxt = r_grant;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_pend) begin
                    w_state_nxt = S_ISSUE;
                    w_write_nxt = 1'b1;
                    w_bt_nxt    = 1'b1;
                    w_addr_nxt  = w_win_addr;
                    w_data0_nxt = w_win_data;
                    w_grant_nxt = w_win_grant;
                end
            end
            S_ISSUE: begin
                w_bt_nxt = 1'b0;
                if (r_write && !avm_waitrequest) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                    w_write_nxt = 1'b0;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_write_nxt = 1'b0;
                w_bt_nxt    = 1'b0;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Pending-flag update and drop accounting; a new pulse beats a same-cycle completion.
    always_comb begin
        w_clr      = w_done ? r_grant : '0;
        w_pend_nxt = w_pulse | (r_pend & ~w_clr);
        w_drop     = w_pulse & r_pend & ~w_clr;
        w_drop_num = '0;
        for (int unsigned i = 0; i < NF; i++) begin
            w_drop_num = w_drop_num + 4'(w_drop[i]);
        end
        w_drop_sum = (DROP_CNT_W + 4)'(r_drop_count) + (DROP_CNT_W + 4)'(w_drop_num);
        if (|w_drop_sum[DROP_CNT_W+3:DROP_CNT_W]) begin
            w_drop_nxt = '1;
        end else begin
            w_drop_nxt = w_drop_sum[DROP_CNT_W-1:0];
        end
        if (clear_req && enable) begin
            w_drop_nxt = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Master output, grant, flag and drop-counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write      <= 1'b0;
            r_bt         <= 1'b0;
            r_addr       <= '0;
            r_data0      <= 1'b0;
            r_grant      <= '0;
            r_pend       <= '0;
            r_drop_count <= '0;
        end else begin
            r_write      <= w_write_nxt;
            r_bt         <= w_bt_nxt;
            r_addr       <= w_addr_nxt;
            r_data0      <= w_data0_nxt;
            r_grant      <= w_grant_nxt;
            r_pend       <= w_pend_nxt;
            r_drop_count <= w_drop_nxt;
        end
    end

    assign avm_address       = r_addr;
    assign avm_write         = r_write;
    assign avm_begintransfer = r_bt;
    assign avm_writedata     = {31'b0, r_data0};
    assign busy              = (r_state != S_IDLE) || (|r_pend);
    assign drop_count        = r_drop_count;

endmodule

// File: tb/tb_perf_section_marker.sv
// Directed bench for perf_section_marker: latency, arbitration order,
// waitrequest stalls, drop counting/saturation/clear, enable gating and reset.
module tb_perf_section_marker;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [NS-1:0] sec_begin;
    logic [NS-1:0] sec_end;
    logic          clear_req;
    logic          enable;
    logic [3:0]    avm_address;
    logic          avm_write;
    logic          avm_begintransfer;
    logic [31:0]   avm_writedata;
    logic          avm_waitrequest;
    logic          busy;
    logic [DW-1:0] drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0]  exp_addr [6];
    logic [31:0] exp_data [6];

    always #5 clk = ~clk;

    perf_section_marker #(
        .NUM_SECTIONS(NS),
        .DROP_CNT_W  (DW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .sec_begin        (sec_begin),
        .sec_end          (sec_end),
        .clear_req        (clear_req),
        .enable           (enable),
        .avm_address      (avm_address),
        .avm_write        (avm_write),
        .avm_begintransfer(avm_begintransfer),
        .avm_writedata    (avm_writedata),
        .avm_waitrequest  (avm_waitrequest),
        .busy             (busy),
        .drop_count       (drop_count)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n         = 1'b0;
        sec_begin       = '0;
        sec_end         = '0;
        clear_req       = 1'b0;
        enable          = 1'b1;
        avm_waitrequest = 1'b0;
        repeat (2) step();

        // Reset state
        check("rst_write", avm_write, 0);
        check("rst_bt", avm_begintransfer, 0);
        check("rst_addr", avm_address, 0);
        check("rst_data", avm_writedata, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_count, 0);
        reset_n = 1'b1;
        step();

        // Single begin then end on section 2
        sec_begin = 4'b0100;
        step();
        sec_begin = '0;
        check("t1_c1_write", avm_write, 0);
        check("t1_c1_busy", busy, 1);
        step();
        check("t1_c2_write", avm_write, 1);
        check("t1_c2_bt", avm_begintransfer, 1);
        check("t1_c2_addr", avm_address, 9);
        check("t1_c2_data", avm_writedata, 0);
        step();
        check("t1_c3_write", avm_write, 0);
        repeat (7) step();
        sec_end = 4'b0100;
        step();
        sec_end = '0;
        step();
        check("t1_c12_write", avm_write, 1);
        check("t1_c12_bt", avm_begintransfer, 1);
        check("t1_c12_addr", avm_address, 8);
        step();
        check("t1_c13_write", avm_write, 0);
        check("t1_c13_busy", busy, 0);

        // Simultaneous clear, all begins, end 0: priority order
        exp_addr[0] = 4'd0;  exp_data[0] = 32'd1;
        exp_addr[1] = 4'd1;  exp_data[1] = 32'd0;
        exp_addr[2] = 4'd5;  exp_data[2] = 32'd0;
        exp_addr[3] = 4'd9;  exp_data[3] = 32'd0;
        exp_addr[4] = 4'd13; exp_data[4] = 32'd0;
        exp_addr[5] = 4'd0;  exp_data[5] = 32'd0;
        sec_begin = 4'b1111;
        sec_end   = 4'b0001;
        clear_req = 1'b1;
        step();
        sec_begin = '0;
        sec_end   = '0;
        clear_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            check($sformatf("t2_w%0d_write", k), avm_write, 1);
            check($sformatf("t2_w%0d_bt", k), avm_begintransfer, 1);
            check($sformatf("t2_w%0d_addr", k), avm_address, exp_addr[k]);
            check($sformatf("t2_w%0d_data", k), avm_writedata, exp_data[k]);
            step();
            check($sformatf("t2_gap%0d_write", k), avm_write, 0);
        end
        check("t2_busy", busy, 0);
        check("t2_drop", drop_count, 0);

        // Waitrequest stall with a redundant pulse on the stalled section
        avm_waitrequest = 1'b1;
        sec_begin = 4'b0010;
        step();
        sec_begin = '0;
        step();
        check("t3_c2_write", avm_write, 1);
        check("t3_c2_bt", avm_begintransfer, 1);
        check("t3_c2_addr", avm_address, 5);
        for (int c = 3; c <= 6; c++) begin
            step();
            sec_begin = (c == 4) ? 4'b0010 : 4'b0000;
            check($sformatf("t3_c%0d_write", c), avm_write, 1);
            check($sformatf("t3_c%0d_bt", c), avm_begintransfer, 0);
            check($sformatf("t3_c%0d_addr", c), avm_address, 5);
            check($sformatf("t3_c%0d_data", c), avm_writedata, 0);
        end
        step();
        avm_waitrequest = 1'b0;
        check("t3_c7_write", avm_write, 1);
        check("t3_c7_addr", avm_address, 5);
        check("t3_c7_drop", drop_count, 1);
        step();
        check("t3_c8_write", avm_write, 0);
        check("t3_c8_busy", busy, 0);
        check("t3_c8_drop", drop_count, 1);
        for (int c = 9; c <= 12; c++) begin
            step();
            check($sformatf("t3_c%0d_nowrite", c), avm_write, 0);
        end

        // Clear drop counter, then saturate on a stalled section
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("t4_clr_drop", drop_count, 0);
        step();
        check("t4_clr_write", avm_write, 1);
        check("t4_clr_addr", avm_address, 0);
        check("t4_clr_data", avm_writedata, 1);
        step();
        check("t4_clr_done", avm_write, 0);
        check("t4_clr_busy", busy, 0);
        avm_waitrequest = 1'b1;
        sec_end = 4'b1000;
        step();
        sec_end = '0;
        step();
        check("t4_stall_write", avm_write, 1);
        check("t4_stall_addr", avm_address, 12);
        for (int p = 1; p <= 300; p++) begin
            sec_end = 4'b1000;
            step();
            sec_end = '0;
            step();
            if (p == 10) check("t4_drop10", drop_count, 10);
        end
        check("t4_drop_sat", drop_count, 255);
        check("t4_sat_addr", avm_address, 12);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("t4_drop_clr", drop_count, 0);
        clear_req = 1'b1;
        sec_end   = 4'b1000;
        step();
        clear_req = 1'b0;
        sec_end   = '0;
        check("t4_clr_beats_inc", drop_count, 0);
        avm_waitrequest = 1'b0;
        check("t4_rel_write", avm_write, 1);
        check("t4_rel_addr", avm_address, 12);
        step();
        check("t4_rel_gap", avm_write, 0);
        step();
        check("t4_rel2_write", avm_write, 1);
        check("t4_rel2_addr", avm_address, 0);
        check("t4_rel2_data", avm_writedata, 1);
        step();
        check("t4_rel2_done", avm_write, 0);
        check("t4_rel2_busy", busy, 0);

        // enable=0 gating: no flags, no writes, no drops
        enable    = 1'b0;
        sec_begin = 4'b1111;
        sec_end   = 4'b1111;
        step();
        step();
        sec_begin = '0;
        sec_end   = '0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("t5_c%0d_write", c), avm_write, 0);
            check($sformatf("t5_c%0d_busy", c), busy, 0);
            check($sformatf("t5_c%0d_drop", c), drop_count, 0);
            step();
        end
        enable = 1'b1;

        // Reset in the middle of a stalled write
        avm_waitrequest = 1'b1;
        sec_begin = 4'b0001;
        step();
        sec_begin = '0;
        step();
        check("t6_write", avm_write, 1);
        check("t6_addr", avm_address, 1);
        sec_begin = 4'b0001;
        sec_end   = 4'b0100;
        step();
        sec_begin = '0;
        sec_end   = '0;
        check("t6_drop", drop_count, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_async_write", avm_write, 0);
        check("t6_async_bt", avm_begintransfer, 0);
        check("t6_async_addr", avm_address, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_drop", drop_count, 0);
        step();
        step();
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("t6_post%0d_write", c), avm_write, 0);
            check($sformatf("t6_post%0d_busy", c), busy, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
